// File: rtl/stream_mux4_rr.sv
// stream_mux4_rr: 4-to-1 valid/ready merge with a burst-locked grant and a registered output beat.
// Arbitration is round-robin by default; define STREAM_MUX_PRIO_EN to make it fixed priority (channel 0 highest).
module stream_mux4_rr #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          in_valid,
  input  logic [4*DATA_W-1:0] in_data,
  output logic [3:0]          in_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          out_sel,
  input  logic                out_ready
);

  // state | meaning
  // IDLE  | no grant held; pick the next requester (costs one clock)
  // BURST | granted channel feeds the output stage, up to BURST_LEN beats
  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [1:0]        grant;
  logic [1:0]        last_grant;
  logic [4:0]        count;

  logic              stage_free;
  logic              grant_valid;
  logic              in_xfer;
  logic              out_xfer;
  logic              burst_done;
  logic [DATA_W-1:0] grant_data;
  logic              arb_hit;
  logic [1:0]        arb_pick;
  logic [1:0]        cand;

  assign stage_free  = !out_valid || out_ready;
  assign grant_valid = in_valid[grant];
  assign grant_data  = in_data[grant*DATA_W +: DATA_W];
  assign in_xfer     = (state == BURST) && grant_valid && stage_free;
  assign out_xfer    = out_valid && out_ready;
  assign burst_done  = (count == 5'(BURST_LEN - 1));
  assign in_ready    = (!rst && state == BURST && stage_free) ? (4'b0001 << grant) : 4'b0000;

  // Descending loops so the highest-priority candidate is the last one assigned.
  always_comb begin
    arb_hit  = 1'b0;
    arb_pick = 2'd0;
    cand     = 2'd0;
`ifdef STREAM_MUX_PRIO_EN
    for (int k = 3; k >= 0; k--) begin
      cand = 2'(k);
      if (in_valid[cand]) begin
        arb_hit  = 1'b1;
        arb_pick = cand;
      end
    end
`else
    for (int k = 4; k >= 1; k--) begin
      cand = last_grant + 2'(k);
      if (in_valid[cand]) begin
        arb_hit  = 1'b1;
        arb_pick = cand;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'b11;
      count      <= 5'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (arb_hit) begin
            state <= BURST;
            grant <= arb_pick;
            count <= 5'd0;
          end
        end
        BURST: begin
          if (!grant_valid) begin
            state      <= IDLE;
            last_grant <= grant;
            count      <= 5'd0;
          end else if (in_xfer) begin
            if (burst_done) begin
              state      <= IDLE;
              last_grant <= grant;
              count      <= 5'd0;
            end else begin
              count <= count + 5'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Release never touches the output stage; a pending beat waits for out_ready.
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux4_rr.md
Name: stream_mux4_rr

Overview:
- 4-to-1 streaming multiplexer. It merges four valid/ready input channels into one output stream and tags each output beat with its source channel.
- It is the gathering counterpart of the 1-to-4 demultiplexer: demux outputs fan out to consumers, and this block collects producer streams back onto one path.
- Round-robin arbitration, burst-locked grant, registered output stage.

Parameters:
- DATA_W, 8, width of each channel's data beat.
- BURST_LEN, 4, maximum beats transferred per grant before re-arbitration (legal range 1..16).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-channel valid; bit i = channel i.
- in_data  input  4*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- in_ready  output  4  per-channel ready; combinational from state and output stage.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_W  registered output data.
- out_sel  output  2  source channel of the current output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, out_sel=2'b00.
  - State=IDLE, beat count=0, last_grant=2'b11, so channel 0 is first in order.
  - in_ready=4'b0000 while in reset.
- Transfer rules:
  - Input transfer on channel i: in_valid[i] && in_ready[i] at the clock edge.
  - Output transfer: out_valid && out_ready.
- FSM states: IDLE, BURST.
- IDLE:
  - in_ready=0.
  - If any in_valid bit is set, grant g = first set bit searching last_grant+1, +2, +3, +4 (mod 4).
  - Next cycle: state=BURST, grant=g, count=0.
  - If no in_valid bit is set, stay in IDLE.
  - The arbitration cycle costs one clock.
- BURST:
  - in_ready[g] = (!out_valid || out_ready). All other in_ready bits are 0.
  - On an input transfer: out_data<=in_data[g], out_sel<=g, out_valid<=1, count<=count+1.
  - When an output transfer occurs without a new input transfer, out_valid<=0.
  - A simultaneous output and input transfer keeps out_valid=1 and loads the new beat. Full throughput is 1 beat/clk.
- Release from BURST to IDLE, with last_grant<=g:
  - (a) the input transfer that makes count reach BURST_LEN, or
  - (b) in_valid[g]=0 in any BURST cycle (the channel ran dry).
  - count resets to 0 on release.
- Latency: data accepted at edge N appears on out_data/out_valid after edge N. From IDLE with a request present, the first beat appears 2 edges later.
- Backpressure: out_valid/out_data/out_sel are held stable while out_valid && !out_ready. No beat is dropped or duplicated.
- Release does not clear the output stage. A pending output beat remains until accepted. A new grant may be issued while it is pending, but input transfer only starts once the stage frees.
- If in_valid[g] drops, no input transfer occurs that cycle.
- Reset mid-burst: all state returns to reset values immediately. In-flight beats are discarded.
- BURST_LEN=1: each accepted beat forces a release, giving per-beat round-robin.

Optional Feature:
- Macro: STREAM_MUX_PRIO_EN.
- Defined: arbitration in IDLE is fixed priority, channel 0 highest, then 1, 2, 3. last_grant is ignored for selection but still updated. Grants are never preempted mid-burst.
- Not defined: round-robin as above.

Test Plan:
1. Reset check: rst=1 asynchronously mid-cycle -> out_valid=0, out_data=0, out_sel=0, in_ready=0000 immediately. After release with no requests, IDLE and in_ready=0000.
2. Single channel: in_valid=0100, ch2 data 8'hA0..8'hA5 continuous, out_ready=1, BURST_LEN=4 -> four beats A0..A3 with out_sel=2. Then one idle arbitration cycle, re-grant ch2, A4, A5.
3. Round-robin fairness: all four in_valid held high, BURST_LEN=1, out_ready=1 -> out_sel sequence 0,1,2,3,0,1... One beat per 2 clocks.
4. Backpressure: ch1 streaming 8'h11,8'h22,8'h33, out_ready low for 3 clocks after first beat -> out_data holds 8'h11 stable, in_ready[1]=0. After out_ready=1, 8'h22 and 8'h33 follow with no loss or duplication.
5. Early release: ch3 granted, in_valid[3] drops after 2 beats while ch0 requesting -> FSM returns to IDLE. Next grant is ch0 (search from last_grant=3). Beat count restarts at 0.
6. With STREAM_MUX_PRIO_EN defined, in_valid=1111, BURST_LEN=1 -> out_sel always 0 while ch0 stays valid. Drop ch0 -> grants go to ch1.
